// File: rtl/uart_bus_port.sv
// Bus responder giving the LSU access to the UART through TX/RX byte FIFOs and DATA/STATUS/CTRL registers.
// Optional macro UART_BUS_PORT_IRQ_EN adds irq_o and makes the CTRL irq-enable bits writable.
module uart_bus_port #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  hb_i,
    output logic [31:0] rdata_o,
    output logic        gnt_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i
`ifdef UART_BUS_PORT_IRQ_EN
    ,
    output logic        irq_o
`endif
);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam logic [TXA:0] TX_ONE = {{TXA{1'b0}}, 1'b1};
    localparam logic [RXA:0] RX_ONE = {{RXA{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACK, RELEASE} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [TXA:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RXA:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    tx_mem_q [TX_DEPTH];
    logic [7:0]    rx_mem_q [RX_DEPTH];
    logic [1:0]    ctrl_rd;

    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic [1:0]  sel;
    logic        is_data, ready, accept;
    logic        tx_push, tx_pop, rx_push, rx_pop, ovr_set, ovr_clr, ctrl_wr;
    logic [7:0]  rx_head;
    logic [31:0] status, rd_mux;

    logic unused_ok;
    assign unused_ok = ^{hb_i, wdata_i[31:8], wdata_i[7:5], addr_i[31:4], addr_i[1:0]};

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TXA] != tx_rd_q[TXA]) && (tx_wr_q[TXA-1:0] == tx_rd_q[TXA-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RXA] != rx_rd_q[RXA]) && (rx_wr_q[RXA-1:0] == rx_rd_q[RXA-1:0]);

    assign tx_valid_o = ~tx_empty;
    assign tx_data_o  = tx_mem_q[tx_rd_q[TXA-1:0]];
    assign rx_head    = rx_mem_q[rx_rd_q[RXA-1:0]];
    assign gnt_o      = gnt_q;
    assign rdata_o    = rdata_q;

    assign sel     = addr_i[3:2];
    assign is_data = (sel == 2'd0);
    assign tx_pop  = tx_valid_o & tx_ready_i;
    // A full TX FIFO still accepts a bus write when the UART drains a byte the same edge.
    assign ready   = ~(is_data & we_i & tx_full & ~tx_pop) & ~(is_data & ~we_i & rx_empty);
    assign accept  = ce_i & req_i & (state_q == IDLE) & ready;
    assign tx_push = accept & is_data & we_i;
    assign rx_pop  = accept & is_data & ~we_i;
    assign rx_push = rx_valid_i & (~rx_full | rx_pop);
    assign ovr_set = rx_valid_i & rx_full & ~rx_pop;
    assign ctrl_wr = accept & we_i & (sel == 2'd2);
    assign ovr_clr = ctrl_wr & wdata_i[4];

    assign status = {27'b0, overrun_q, tx_full, tx_empty, rx_full, rx_empty};

    always_comb begin
        rd_mux = '0;
        case (sel)
            2'd0:    rd_mux = {24'b0, rx_head};
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {30'b0, ctrl_rd};
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = 1'b0;
        rdata_d   = rdata_q;
        tx_wr_d   = tx_wr_q;
        tx_rd_d   = tx_rd_q;
        rx_wr_d   = rx_wr_q;
        rx_rd_d   = rx_rd_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = ACK;
                gnt_d   = 1'b1;
                if (!we_i) rdata_d = rd_mux;
            end
            ACK:     state_d = RELEASE;
            // Hold off until the initiator lets go so a held request is not serviced twice.
            RELEASE: if (!req_i || !ce_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tx_push) tx_wr_d = tx_wr_q + TX_ONE;
        if (tx_pop)  tx_rd_d = tx_rd_q + TX_ONE;
        if (rx_push) rx_wr_d = rx_wr_q + RX_ONE;
        if (rx_pop)  rx_rd_d = rx_rd_q + RX_ONE;
        if (ovr_set)      overrun_d = 1'b1;
        else if (ovr_clr) overrun_d = 1'b0;
    end

`ifdef UART_BUS_PORT_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;
    assign ctrl_rd = ctrl_q;
    assign irq_o   = irq_q;
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_wr) ctrl_d = wdata_i[1:0];
        irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) | overrun_q;
    end
`else
    assign ctrl_rd = 2'b00;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            rdata_q   <= '0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            overrun_q <= 1'b0;
`ifdef UART_BUS_PORT_IRQ_EN
            ctrl_q    <= '0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rdata_q   <= rdata_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            overrun_q <= overrun_d;
`ifdef UART_BUS_PORT_IRQ_EN
            ctrl_q    <= ctrl_d;
            irq_q     <= irq_d;
`endif
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wr_q[TXA-1:0]] <= wdata_i[7:0];
        if (rx_push) rx_mem_q[rx_wr_q[RXA-1:0]] <= rx_data_i;
    end
endmodule

// File: tb/tb_uart_bus_port.sv
// Self-checking bench for uart_bus_port: directed scenarios plus random traffic against a queue-based model.
module tb_uart_bus_port;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ce_i = 1'b0, req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [1:0]  hb_i = '0;
    logic [31:0] rdata_o;
    logic        gnt_o, tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b0, rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
`ifdef UART_BUS_PORT_IRQ_EN
    logic        irq_o;
`endif

    uart_bus_port #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .hb_i(hb_i), .rdata_o(rdata_o), .gnt_o(gnt_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i)
`ifdef UART_BUS_PORT_IRQ_EN
        , .irq_o(irq_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       ovr = 1'b0;
    logic [1:0] ctrl_m = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        logic txf, txe, rxf, rxe;
        txf = (tx_q.size() == TXD);
        txe = (tx_q.size() == 0);
        rxf = (rx_q.size() == RXD);
        rxe = (rx_q.size() == 0);
        return {27'b0, ovr, txf, txe, rxf, rxe};
    endfunction

    task automatic drive_req(input bit we, input logic [1:0] sel, input logic [7:0] wd);
        ce_i = 1'b1; req_i = 1'b1; we_i = we;
        addr_i  = {$urandom_range(0, 15) == 0 ? 28'hFFFF_FFF : 28'h0, sel, 2'($urandom_range(0, 3))};
        wdata_i = {24'($urandom), wd};
        hb_i    = 2'($urandom_range(0, 3));
    endtask

    task automatic release_req();
        req_i = 1'b0; ce_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    // Raise a request, wait up to budget edges for the grant, then release.
    task automatic bus(input bit we, input logic [1:0] sel, input logic [7:0] wd, input int budget,
                       output bit granted, output logic [31:0] rd, output int lat);
        granted = 1'b0; rd = '0; lat = 0;
        drive_req(we, sel, wd);
        for (int i = 1; i <= budget && !granted; i++) begin
            @(posedge clk_i); #1;
            if (gnt_o === 1'b1) begin
                granted = 1'b1; rd = rdata_o; lat = i;
            end
        end
        req_i = 1'b0; ce_i = 1'b0;
        if (granted) begin
            @(posedge clk_i); #1;
            chk("gnt_one_cycle", {31'b0, gnt_o}, 32'd0);
            @(posedge clk_i); #1;
        end else begin
            repeat (2) @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wr_data(input logic [7:0] b);
        bit g; logic [31:0] rd; int lat; bit exp_g;
        exp_g = (tx_q.size() < TXD);
        bus(1'b1, 2'd0, b, 3, g, rd, lat);
        chk("wr_data_grant", {31'b0, g}, {31'b0, exp_g});
        if (g) begin
            chk("wr_data_latency", lat, 1);
            tx_q.push_back(b);
        end
    endtask

    task automatic rd_data();
        bit g; logic [31:0] rd; int lat; bit exp_g;
        exp_g = (rx_q.size() > 0);
        bus(1'b0, 2'd0, 8'h00, 3, g, rd, lat);
        chk("rd_data_grant", {31'b0, g}, {31'b0, exp_g});
        if (g) chk("rd_data_value", rd, {24'b0, rx_q.pop_front()});
    endtask

    task automatic rd_reg(input logic [1:0] sel, input string tag);
        bit g; logic [31:0] rd; int lat; logic [31:0] e;
        if (sel == 2'd1)      e = status_exp();
        else if (sel == 2'd2) e = {30'b0, ctrl_m};
        else                  e = '0;
        bus(1'b0, sel, 8'h00, 3, g, rd, lat);
        chk({tag, "_grant"}, {31'b0, g}, 32'd1);
        chk(tag, rd, e);
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [7:0] v);
        bit g; logic [31:0] rd; int lat;
        bus(1'b1, sel, v, 3, g, rd, lat);
        chk("wr_reg_grant", {31'b0, g}, 32'd1);
        if (sel == 2'd2) begin
            if (v[4]) ovr = 1'b0;
`ifdef UART_BUS_PORT_IRQ_EN
            ctrl_m = v[1:0];
`endif
        end
    endtask

    task automatic rx_inject(input logic [7:0] b);
        rx_valid_i = 1'b1; rx_data_i = b;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
        if (rx_q.size() < RXD) rx_q.push_back(b);
        else ovr = 1'b1;
    endtask

    task automatic tx_drain();
        chk("tx_valid", {31'b0, tx_valid_o}, {31'b0, tx_q.size() > 0});
        if (tx_q.size() > 0) chk("tx_data", {24'b0, tx_data_o}, {24'b0, tx_q[0]});
        tx_ready_i = 1'b1;
        @(posedge clk_i); #1;
        tx_ready_i = 1'b0;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
    endtask

    initial begin
        bit g; int cnt;
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_gnt", {31'b0, gnt_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rd_reg(2'd1, "status_after_reset");

        // Single TX byte
        wr_data(8'h41);
        chk("tx_valid_41", {31'b0, tx_valid_o}, 32'd1);
        tx_drain();
        rd_reg(2'd1, "status_tx_drained");

        // TX full stall then release by a same-cycle UART pop
        for (int i = 0; i < 8; i++) wr_data(8'(i));
        drive_req(1'b1, 2'd0, 8'h08);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("tx_full_stall", {31'b0, gnt_o}, 32'd0);
        end
        chk("tx_head_before_pop", {24'b0, tx_data_o}, 32'h00);
        tx_ready_i = 1'b1;
        @(posedge clk_i); #1;
        tx_ready_i = 1'b0;
        void'(tx_q.pop_front());
        g = gnt_o;
        for (int i = 0; i < 3 && !g; i++) begin
            @(posedge clk_i); #1;
            g = gnt_o;
        end
        chk("tx_full_release_grant", {31'b0, g}, 32'd1);
        tx_q.push_back(8'h08);
        release_req();
        for (int i = 0; i < 8; i++) tx_drain();
        chk("tx_drained_valid", {31'b0, tx_valid_o}, 32'd0);

        // RX empty stall, then a byte arrives while the request is held
        drive_req(1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("rx_empty_stall", {31'b0, gnt_o}, 32'd0);
        end
        rx_inject(8'h5A);
        g = gnt_o;
        for (int i = 0; i < 3 && !g; i++) begin
            @(posedge clk_i); #1;
            g = gnt_o;
        end
        chk("rx_arrival_grant", {31'b0, g}, 32'd1);
        chk("rx_arrival_rdata", rdata_o, {24'b0, rx_q.pop_front()});
        release_req();
        rd_reg(2'd1, "status_after_rx_pop");

        // Overrun: nine bytes into an eight-entry RX FIFO
        for (int i = 0; i < 9; i++) rx_inject(8'hA0 + 8'(i));
        rd_reg(2'd1, "status_overrun");
        wr_reg(2'd2, 8'h10);
        rd_reg(2'd1, "status_overrun_cleared");
        for (int i = 0; i < 8; i++) rd_data();

        // Held request produces exactly one grant and one pop
        rx_inject(8'hC1);
        rx_inject(8'hC2);
        drive_req(1'b0, 2'd0, 8'h00);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            if (gnt_o) cnt++;
        end
        chk("held_req_one_grant", cnt, 1);
        chk("held_req_rdata", rdata_o, {24'b0, rx_q.pop_front()});
        release_req();
        rd_data();

        // CTRL and reserved register
        wr_reg(2'd2, 8'h03);
        rd_reg(2'd2, "ctrl_readback");
        wr_reg(2'd3, 8'hFF);
        rd_reg(2'd3, "reg3_reads_zero");
        wr_reg(2'd2, 8'h00);

        // Reset asserted while the grant is being presented
        rx_inject(8'h77);
        wr_data(8'h11);
        drive_req(1'b0, 2'd0, 8'h00);
        @(posedge clk_i); #1;
        chk("ack_gnt", {31'b0, gnt_o}, 32'd1);
        chk("ack_rdata", rdata_o, 32'h77);
        #1 rst_i = 1'b1;
        #1;
        chk("rst_async_gnt", {31'b0, gnt_o}, 32'd0);
        chk("rst_async_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        chk("rst_async_rdata", rdata_o, 32'd0);
        req_i = 1'b0; ce_i = 1'b0;
        tx_q.delete(); rx_q.delete(); ovr = 1'b0; ctrl_m = 2'b00;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rd_reg(2'd1, "status_after_midtxn_reset");

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0, 1: wr_data(8'($urandom));
                2:    rd_data();
                3, 4: rx_inject(8'($urandom));
                5:    tx_drain();
                6:    rd_reg(2'd1, "rand_status");
                default: begin
                    wr_reg(2'd2, {3'b0, 1'($urandom_range(0, 1)), 2'b0, 2'($urandom)});
                    rd_reg(2'd2, "rand_ctrl");
                end
            endcase
        end
        rd_reg(2'd1, "final_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
